branch_predictor: RTL and testbench
===================================

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 The module SHALL have parameter ENTRIES, default 16, meaning number of table entries; it must be a power of two, at least 2.
REQ-002 The module SHALL have parameter CTR_BITS, default 2, meaning saturating counter width; legal range 1..4.
REQ-003 The module SHALL have parameter STAT_W, default 32, meaning statistics counter width.
REQ-004 clk  in  1  Clock; single clock domain, all state updates on the rising edge.
REQ-005 rst_n  in  1  Reset; asynchronous, active-low.
REQ-006 lookup_pc  in  Addr  Fetch-stage PC being predicted.
REQ-007 predict_taken  out  Bool  Predict the branch at lookup_pc as taken.
REQ-008 predict_target  out  Addr  Predicted target; valid only when predict_taken=1, else 0.
REQ-009 update_valid  in  Bool  Execute-stage resolved a branch/jump this cycle.
REQ-010 update_pc  in  Addr  PC of the resolved instruction.
REQ-011 update_taken  in  Bool  Actual outcome.
REQ-012 update_target  in  Addr  Actual target.
REQ-013 update_mispredict  in  Bool  Execute stage discarded younger instructions for this update.
REQ-014 stat_updates  out  STAT_W  Count of accepted updates.
REQ-015 stat_mispredicts  out  STAT_W  Count of updates flagged as mispredicted.

Function
REQ-016 Index SHALL be lookup_pc/update_pc bits [IDX_W+1:2], IDX_W=log2(ENTRIES); bits [1:0] ignored; tag SHALL be bits [31:IDX_W+2].
REQ-017 Each entry SHALL hold valid, tag, target (Addr) and counter (CTR_BITS).
REQ-018 Lookup SHALL be combinational from registered table: hit = valid && tag match; predict_taken = hit && counter MSB; zero-cycle latency.
REQ-019 On update_valid with hit: counter SHALL saturating-increment if taken (stops at all-ones), saturating-decrement if not taken (stops at 0); target rewritten with update_target when taken.
REQ-020 On update_valid with miss and update_taken=1: entry SHALL be allocated (overwriting any occupant), valid=1, tag/target written, counter = weakly taken (MSB=1, others 0).
REQ-021 On update_valid with miss and update_taken=0: table SHALL be unchanged.
REQ-022 Table writes SHALL take effect on the clock edge ending the update cycle; a same-cycle lookup of the same index SHALL see pre-update contents.
REQ-023 update_* inputs SHALL be ignored when update_valid=0.
REQ-024 stat_updates SHALL increment by 1 per cycle with update_valid=1; stat_mispredicts SHALL increment when update_valid && update_mispredict; both wrap modulo 2^STAT_W.
REQ-025 update_mispredict with update_valid=0 SHALL have no effect.
REQ-026 CTR_BITS=1 SHALL degenerate to a last-outcome predictor with identical allocation rules.

Reset
REQ-027 Asserting rst_n low SHALL immediately clear all valid bits, counters, targets, tags and both statistics counters, regardless of an update in flight.
REQ-028 During and directly after reset predict_taken SHALL be 0 and predict_target 0 for every lookup_pc.
REQ-029 An update coinciding with reset deassertion edge SHALL be dropped.

Structure
REQ-030 Addr, Bool, Clock, and a BpEntry struct typedef SHALL live in the shared CPU package; ENTRIES/CTR_BITS defaults SHALL be package constants.
REQ-031 A sub-module sat_counter (parameter CTR_BITS; inc, dec, value in, value out) SHALL implement saturation and be instantiated once on the update path.

Verification
REQ-032 Reset, lookup 0x100 -> predict_taken=0, target=0.
REQ-033 Update pc=0x100 taken target=0x200, next cycle lookup 0x100 -> taken=1, target=0x200; counter=2'b10.
REQ-034 Three further taken updates at 0x100 -> counter saturates at 2'b11; then two not-taken -> still taken=1 after first, 0 after second (counter 2'b01).
REQ-035 ENTRIES=16: allocate 0x100 then taken update 0x140 (same index, different tag) -> lookup 0x100 misses, 0x140 hits.
REQ-036 Lookup and update same index same cycle -> lookup returns old value; next cycle returns new.
REQ-037 STAT_W=4, 17 updates with mispredict on 3 -> stat_updates=1, stat_mispredicts=3; async rst_n mid-sequence clears both and all entries without a clock edge.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// Shared CPU types and defaults for the branch predictor slice.
// BpEntry is sized for the widest legal counter; narrower configs use the low bits.
package branch_predictor_pkg;

  typedef logic [31:0] Addr;
  typedef logic        Bool;
  typedef logic        Clock;

  localparam int unsigned ENTRIES_DEF  = 16;
  localparam int unsigned CTR_BITS_DEF = 2;
  localparam int unsigned CTR_MAX      = 4;

  typedef struct packed {
    Bool                valid;
    Addr                tag;
    Addr                target;
    logic [CTR_MAX-1:0] ctr;
  } BpEntry;

  // Tag is kept right-justified so it compares as a full Addr.
  function automatic Addr pc_tag(input Addr pc, input int unsigned idx_w);
    return pc >> (idx_w + 2);
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch-lookup / execute-update / statistics bundle for the branch predictor.
interface branch_predictor_if
  import branch_predictor_pkg::*;
#(
  parameter int unsigned STAT_W = 32
);
  Addr               lookup_pc;
  Bool               predict_taken;
  Addr               predict_target;
  Bool               update_valid;
  Addr               update_pc;
  Bool               update_taken;
  Addr               update_target;
  Bool               update_mispredict;
  logic [STAT_W-1:0] stat_updates;
  logic [STAT_W-1:0] stat_mispredicts;

  modport master (
    output lookup_pc, update_valid, update_pc, update_taken, update_target, update_mispredict,
    input  predict_taken, predict_target, stat_updates, stat_mispredicts
  );

  modport slave (
    input  lookup_pc, update_valid, update_pc, update_taken, update_target, update_mispredict,
    output predict_taken, predict_target, stat_updates, stat_mispredicts
  );
endinterface

// File: rtl/branch_predictor_sat_counter.sv
// Saturating up/down counter used on the predictor update path.
module sat_counter #(
  parameter int unsigned CTR_BITS = 2
) (
  input  logic                i_inc,
  input  logic                i_dec,
  input  logic [CTR_BITS-1:0] i_value,
  output logic [CTR_BITS-1:0] o_value
);
  always_comb begin
    o_value = i_value;
    if (i_inc && !i_dec && (i_value != '1)) begin
      o_value = i_value + CTR_BITS'(1);
    end else if (i_dec && !i_inc && (i_value != '0)) begin
      o_value = i_value - CTR_BITS'(1);
    end
  end
endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with per-entry saturating direction counters.
// Lookup is combinational from the registered table; updates commit on the clock edge.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int unsigned ENTRIES  = ENTRIES_DEF,
  parameter int unsigned CTR_BITS = CTR_BITS_DEF,
  parameter int unsigned STAT_W   = 32
) (
  input  Clock                clk,
  input  logic                rst_n,
  branch_predictor_if.slave   bus
);
  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam logic [CTR_BITS-1:0] WEAK_TAKEN = CTR_BITS'(1) << (CTR_BITS - 1);

  BpEntry              r_tab [ENTRIES];
  logic                r_armed;
  logic [STAT_W-1:0]   r_stat_upd;
  logic [STAT_W-1:0]   r_stat_mis;

  logic [IDX_W-1:0]    w_lidx;
  logic [IDX_W-1:0]    w_uidx;
  BpEntry              w_lent;
  BpEntry              w_uent;
  Bool                 w_lhit;
  Bool                 w_uhit;
  logic [CTR_BITS-1:0] w_ctr_next;
  logic                w_unused;

  assign w_lidx = bus.lookup_pc[IDX_W+1:2];
  assign w_uidx = bus.update_pc[IDX_W+1:2];
  assign w_lent = r_tab[w_lidx];
  assign w_uent = r_tab[w_uidx];
  assign w_lhit = w_lent.valid && (w_lent.tag == pc_tag(bus.lookup_pc, IDX_W));
  assign w_uhit = w_uent.valid && (w_uent.tag == pc_tag(bus.update_pc, IDX_W));

  assign bus.predict_taken    = w_lhit && w_lent.ctr[CTR_BITS-1];
  assign bus.predict_target   = bus.predict_taken ? w_lent.target : '0;
  assign bus.stat_updates     = r_stat_upd;
  assign bus.stat_mispredicts = r_stat_mis;

  // Byte-offset bits and counter bits above CTR_BITS carry no information.
  assign w_unused = ^{bus.lookup_pc[1:0], bus.update_pc[1:0], w_lent.ctr, w_uent.ctr};

  sat_counter #(.CTR_BITS(CTR_BITS)) u_sat_counter (
    .i_inc   (bus.update_taken),
    .i_dec   (!bus.update_taken),
    .i_value (w_uent.ctr[CTR_BITS-1:0]),
    .o_value (w_ctr_next)
  );

  // r_armed stays low through the first edge after reset release so an
  // update presented on that edge is discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        r_tab[i] <= '0;
      end
      r_armed    <= 1'b0;
      r_stat_upd <= '0;
      r_stat_mis <= '0;
    end else begin
      r_armed <= 1'b1;
      if (r_armed && bus.update_valid) begin
        r_stat_upd <= r_stat_upd + STAT_W'(1);
        if (bus.update_mispredict) begin
          r_stat_mis <= r_stat_mis + STAT_W'(1);
        end
        if (w_uhit) begin
          r_tab[w_uidx].ctr <= CTR_MAX'(w_ctr_next);
          if (bus.update_taken) begin
            r_tab[w_uidx].target <= bus.update_target;
          end
        end else if (bus.update_taken) begin
          r_tab[w_uidx] <= '{valid:  1'b1,
                             tag:    pc_tag(bus.update_pc, IDX_W),
                             target: bus.update_target,
                             ctr:    CTR_MAX'(WEAK_TAKEN)};
        end
      end
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// Directed, table-driven check of branch_predictor plus hand-written reset and 1-bit sequences.
module tb_branch_predictor;
  import branch_predictor_pkg::*;

  logic clk;
  logic rst_n;
  int   n_total;
  int   n_pass;

  branch_predictor_if #(.STAT_W(4)) bus  ();
  branch_predictor_if #(.STAT_W(4)) bus1 ();

  branch_predictor #(.ENTRIES(16), .CTR_BITS(2), .STAT_W(4)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  branch_predictor #(.ENTRIES(2), .CTR_BITS(1), .STAT_W(4)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        uv;
    logic [31:0] upc;
    logic        ut;
    logic [31:0] utgt;
    logic        um;
    logic [31:0] lpc;
    logic        et;
    logic [31:0] etgt;
  } vec_t;

  vec_t v [24];

  function automatic vec_t mk(input logic uv, input logic [31:0] upc, input logic ut,
                              input logic [31:0] utgt, input logic um, input logic [31:0] lpc,
                              input logic et, input logic [31:0] etgt);
    vec_t r;
    r.uv = uv; r.upc = upc; r.ut = ut; r.utgt = utgt; r.um = um;
    r.lpc = lpc; r.et = et; r.etgt = etgt;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;

    // Expected prediction is sampled before the row's edge (pre-update contents).
    v[0]  = mk(0, 32'h000, 0, 32'h000, 0, 32'h100, 0, 32'h000);
    v[1]  = mk(1, 32'h100, 1, 32'h200, 0, 32'h100, 0, 32'h000);
    v[2]  = mk(1, 32'h100, 1, 32'h200, 0, 32'h100, 1, 32'h200);
    v[3]  = mk(1, 32'h100, 1, 32'h200, 0, 32'h100, 1, 32'h200);
    v[4]  = mk(1, 32'h100, 1, 32'h200, 0, 32'h100, 1, 32'h200);
    v[5]  = mk(1, 32'h100, 0, 32'h000, 1, 32'h100, 1, 32'h200);
    v[6]  = mk(1, 32'h100, 0, 32'h000, 0, 32'h100, 1, 32'h200);
    v[7]  = mk(0, 32'h000, 0, 32'h000, 0, 32'h100, 0, 32'h000);
    v[8]  = mk(1, 32'h100, 1, 32'h300, 1, 32'h100, 0, 32'h000);
    v[9]  = mk(1, 32'h140, 1, 32'h400, 0, 32'h100, 1, 32'h300);
    v[10] = mk(0, 32'h000, 0, 32'h000, 0, 32'h100, 0, 32'h000);
    v[11] = mk(0, 32'h000, 0, 32'h000, 0, 32'h140, 1, 32'h400);
    v[12] = mk(1, 32'h144, 0, 32'h000, 1, 32'h144, 0, 32'h000);
    v[13] = mk(0, 32'h000, 0, 32'h000, 0, 32'h144, 0, 32'h000);
    v[14] = mk(0, 32'h140, 0, 32'h000, 1, 32'h140, 1, 32'h400);
    v[15] = mk(0, 32'h000, 0, 32'h000, 0, 32'h140, 1, 32'h400);
    for (int i = 16; i < 24; i++) begin
      v[i] = mk(1, 32'h180, 0, 32'h000, 0, 32'h180, 0, 32'h000);
    end

    bus.lookup_pc = 32'h100; bus.update_valid = 0; bus.update_pc = '0;
    bus.update_taken = 0; bus.update_target = '0; bus.update_mispredict = 0;
    bus1.lookup_pc = 32'h8; bus1.update_valid = 0; bus1.update_pc = '0;
    bus1.update_taken = 0; bus1.update_target = '0; bus1.update_mispredict = 0;

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_taken", 32'(bus.predict_taken), 32'h0);
    check("reset_target", bus.predict_target, 32'h0);
    check("reset_stat_upd", 32'(bus.stat_updates), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      bus.update_valid      = v[i].uv;
      bus.update_pc         = v[i].upc;
      bus.update_taken      = v[i].ut;
      bus.update_target     = v[i].utgt;
      bus.update_mispredict = v[i].um;
      bus.lookup_pc         = v[i].lpc;
      #1;
      check($sformatf("row%0d_taken", i), 32'(bus.predict_taken), 32'(v[i].et));
      check($sformatf("row%0d_target", i), bus.predict_target, v[i].etgt);
    end
    @(negedge clk);
    bus.update_valid = 0;
    bus.lookup_pc    = 32'h140;
    #1;
    check("stat_updates_wrap", 32'(bus.stat_updates), 32'd1);
    check("stat_mispredicts", 32'(bus.stat_mispredicts), 32'd3);
    check("pre_reset_hit_0x140", 32'(bus.predict_taken), 32'h1);

    // 1-bit counter: last outcome decides, allocation still on taken miss only.
    bus1.update_valid = 1; bus1.update_pc = 32'h8; bus1.update_taken = 1; bus1.update_target = 32'h40;
    #1;
    check("c1_before_alloc", 32'(bus1.predict_taken), 32'h0);
    @(negedge clk);
    bus1.update_taken = 0;
    #1;
    check("c1_after_taken", 32'(bus1.predict_taken), 32'h1);
    check("c1_target", bus1.predict_target, 32'h40);
    @(negedge clk);
    bus1.update_taken = 1; bus1.update_target = 32'h44;
    #1;
    check("c1_after_not_taken", 32'(bus1.predict_taken), 32'h0);
    check("c1_target_zero", bus1.predict_target, 32'h0);
    @(negedge clk);
    bus1.update_valid = 0;
    #1;
    check("c1_retaken", 32'(bus1.predict_taken), 32'h1);
    check("c1_new_target", bus1.predict_target, 32'h44);
    check("c1_stat_upd", 32'(bus1.stat_updates), 32'd3);

    // Asynchronous reset mid-cycle, no clock edge in between.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_taken", 32'(bus.predict_taken), 32'h0);
    check("async_rst_target", bus.predict_target, 32'h0);
    check("async_rst_stat_upd", 32'(bus.stat_updates), 32'h0);
    check("async_rst_stat_mis", 32'(bus.stat_mispredicts), 32'h0);
    check("async_rst_c1", 32'(bus1.predict_taken), 32'h0);

    // Update held across reset release must not land on the release edge.
    bus.update_valid = 1; bus.update_pc = 32'h100; bus.update_taken = 1;
    bus.update_target = 32'h200; bus.update_mispredict = 1; bus.lookup_pc = 32'h100;
    @(negedge clk);
    #1;
    check("in_reset_taken", 32'(bus.predict_taken), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    bus.update_valid = 0;
    #1;
    check("release_drop_taken", 32'(bus.predict_taken), 32'h0);
    check("release_drop_target", bus.predict_target, 32'h0);
    check("release_drop_stat_upd", 32'(bus.stat_updates), 32'h0);
    check("release_drop_stat_mis", 32'(bus.stat_mispredicts), 32'h0);
    @(negedge clk);
    #1;
    check("post_release_idle", 32'(bus.predict_taken), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
